// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl_pkg
// Description : Shared MD operation codes, default latencies and FSM states
//               for the E-stage multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || is_div(op);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
// Module      : md_arith
// Description : Combinational multiply/divide datapath producing {HI,LO}
//               and a divide-by-zero flag from latched operands.
// Revision    : 1.0 - initial release
// ============================================================================
module md_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        divzero
);

    logic               w_bzero;
    logic               w_sovf;
    logic signed [31:0] w_sdivisor;
    logic        [31:0] w_udivisor;
    logic signed [63:0] w_smul;
    logic        [63:0] w_umul;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic        [31:0] w_uq;
    logic        [31:0] w_ur;

    assign w_bzero = (b == 32'd0);
    assign w_sovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Dividing by 1 yields the architected result for both zero-divisor
    // (discarded anyway) and the -2^31 / -1 overflow case (q = a, r = 0).
    assign w_sdivisor = (w_bzero || w_sovf) ? 32'sd1 : $signed(b);
    assign w_udivisor = w_bzero ? 32'd1 : b;

    assign w_smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_umul = {32'd0, a} * {32'd0, b};
    assign w_sq   = $signed(a) / w_sdivisor;
    assign w_sr   = $signed(a) % w_sdivisor;
    assign w_uq   = a / w_udivisor;
    assign w_ur   = a % w_udivisor;

    always_comb begin
        res = 64'd0;
        case (op)
            MD_MULT:  res = w_smul;
            MD_MULTU: res = w_umul;
            MD_DIV:   res = {w_sr, w_sq};
            MD_DIVU:  res = {w_ur, w_uq};
            default:  res = 64'd0;
        endcase
    end

    assign divzero = is_div(op) && w_bzero;

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : E-stage multiply/divide controller: fixed-latency FSM,
//               HI/LO ownership, move-to/from and hazard stall request.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDOpE,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MDUseD,
    output logic        Busy,
    output logic        StallMD,
    output logic [31:0] MDOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

    state_t      r_state, w_state;
    logic [3:0]  r_cnt,   w_cnt;
    logic [3:0]  r_op,    w_op;
    logic [31:0] r_a,     w_a;
    logic [31:0] r_b,     w_b;
    logic [31:0] r_hi,    w_hi;
    logic [31:0] r_lo,    w_lo;

    logic        w_start;
    logic [63:0] w_res;
    logic        w_divzero;

    md_arith u_arith (
        .op      (r_op),
        .a       (r_a),
        .b       (r_b),
        .res     (w_res),
        .divzero (w_divzero)
    );

    assign w_start = is_start(MDOpE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= MD_NONE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_op    <= w_op;
            r_a     <= w_a;
            r_b     <= w_b;
            r_hi    <= w_hi;
            r_lo    <= w_lo;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_op    = r_op;
        w_a     = r_a;
        w_b     = r_b;
        w_hi    = r_hi;
        w_lo    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state = S_BUSY;
                    w_cnt   = is_div(MDOpE) ? c_DIV_CNT : c_MULT_CNT;
                    w_op    = MDOpE;
                    w_a     = A;
                    w_b     = B;
                end else if (MDOpE == MD_MTHI) begin
                    w_hi = A;
                end else if (MDOpE == MD_MTLO) begin
                    w_lo = A;
                end
            end
            S_BUSY: begin
                // Issue requests and moves are ignored here; the hazard unit
                // is expected to have held them back.
                w_cnt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state = S_IDLE;
                    if (!w_divzero) begin
                        w_hi = w_res[63:32];
                        w_lo = w_res[31:0];
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign Busy    = (r_state == S_BUSY);
    assign StallMD = MDUseD & (Busy | w_start);
    assign HI      = r_hi;
    assign LO      = r_lo;

    always_comb begin
        MDOut = 32'd0;
        if (MDOpE == MD_MFHI) begin
            MDOut = r_hi;
        end else if (MDOpE == MD_MFLO) begin
            MDOut = r_lo;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Directed, table-driven self-checking bench for mdu_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDOpE;
    logic [31:0] A;
    logic [31:0] B;
    logic        MDUseD;
    logic        Busy;
    logic        StallMD;
    logic [31:0] MDOut;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[11];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .MDOpE   (MDOpE),
        .A       (A),
        .B       (B),
        .MDUseD  (MDUseD),
        .Busy    (Busy),
        .StallMD (StallMD),
        .MDOut   (MDOut),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Issue one op for a single cycle and count the Busy cycles that follow.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        MDOpE = op;
        A     = a;
        B     = b;
        tick;
        MDOpE = MD_NONE;
        cyc   = 0;
        while (Busy && cyc < 40) begin
            cyc++;
            tick;
        end
    endtask

    initial begin
        int cyc;
        int stalls;

        vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{MD_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        vecs[6]  = '{MD_MULT,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[7]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[8]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[9]  = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
        vecs[10] = '{MD_DIV,   32'd0,        32'd0,        32'h00000000, 32'h00000001, 10};

        reset  = 1'b1;
        MDOpE  = MD_NONE;
        A      = 32'd0;
        B      = 32'd0;
        MDUseD = 1'b0;
        tick;
        tick;
        chk("reset_busy",  {31'd0, Busy}, 32'd0);
        chk("reset_hi",    HI, 32'd0);
        chk("reset_lo",    LO, 32'd0);
        chk("reset_stall", {31'd0, StallMD}, 32'd0);
        reset = 1'b0;
        tick;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
            chk($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
        end

        // Hazard: mflo waits in D while a mult is issued and runs.
        MDUseD = 1'b1;
        MDOpE  = MD_MULT;
        A      = 32'd5;
        B      = 32'd6;
        #1;
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            if (!StallMD) break;
            stalls++;
            tick;
            MDOpE = MD_NONE;
        end
        chk("hazard_stall_cycles", stalls, 32'd6);
        MDUseD = 1'b0;
        MDOpE  = MD_MFLO;
        #1;
        chk("hazard_mflo", MDOut, 32'd30);
        chk("hazard_busy", {31'd0, Busy}, 32'd0);

        // mthi then mfhi; MDOut idles at zero.
        MDOpE = MD_MTHI;
        A     = 32'h12345678;
        tick;
        chk("mthi_hi", HI, 32'h12345678);
        MDOpE = MD_MFHI;
        #1;
        chk("mfhi_out", MDOut, 32'h12345678);
        MDOpE = MD_NONE;
        #1;
        chk("none_out", MDOut, 32'd0);

        // mtlo and a stray div issue while busy must both be ignored.
        MDOpE = MD_MULT;
        A     = 32'd2;
        B     = 32'd3;
        tick;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (!Busy) break;
            cyc++;
            if (cyc == 1) begin
                MDOpE = MD_MTLO;
                A     = 32'hDEADBEEF;
            end else if (cyc == 2) begin
                MDOpE = MD_DIV;
                A     = 32'd100;
                B     = 32'd7;
            end else begin
                MDOpE = MD_NONE;
            end
            tick;
        end
        MDOpE = MD_NONE;
        chk("busy_ignore_cycles", cyc, 32'd5);
        chk("busy_ignore_hi", HI, 32'd0);
        chk("busy_ignore_lo", LO, 32'd6);

        // Reset at busy cycle 3 of a div aborts it with no late write-back.
        MDOpE = MD_DIV;
        A     = 32'd100;
        B     = 32'd7;
        tick;
        MDOpE = MD_NONE;
        tick;
        tick;
        reset = 1'b1;
        tick;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        MDOpE = MD_MULT;
        A     = 32'd9;
        B     = 32'd9;
        tick;
        chk("reset_wins_busy", {31'd0, Busy}, 32'd0);
        reset = 1'b0;
        MDOpE = MD_NONE;
        repeat (12) tick;
        chk("abort_late_busy", {31'd0, Busy}, 32'd0);
        chk("abort_late_hi", HI, 32'd0);
        chk("abort_late_lo", LO, 32'd0);

        // Back-to-back: second mult issued in the first cycle Busy is low.
        run_op(MD_MULT, 32'd3, 32'd4, cyc);
        chk("b2b_first_lo", LO, 32'd12);
        MDOpE = MD_MULT;
        A     = 32'd5;
        B     = 32'd5;
        tick;
        MDOpE = MD_NONE;
        chk("b2b_accept", {31'd0, Busy}, 32'd1);
        cyc = 0;
        while (Busy && cyc < 40) begin
            cyc++;
            tick;
        end
        chk("b2b_cycles", cyc, 32'd5);
        chk("b2b_hi", HI, 32'd0);
        chk("b2b_lo", LO, 32'd25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit controller for the E stage of the 5-stage MIPS pipeline. It executes mult/multu/div/divu with fixed multi-cycle latency, owns the HI/LO registers, and serves mthi/mtlo/mfhi/mflo. It raises a stall request to the hazard unit while a multi-cycle operation is in flight and a dependent multiply/divide-class instruction is waiting in D.

Parameters:
MULT_CYCLES, 5, Busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, Busy cycles for div/divu (legal range 1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
MDOpE  in  4  E-stage MD operation, encoded as in the shared package
A  in  32  rs operand, forwarded value
B  in  32  rt operand, forwarded value
MDUseD  in  1  D-stage instruction is any of the eight MD-class ops
Busy  out  1  multi-cycle operation in flight
StallMD  out  1  stall request to the hazard unit
MDOut  out  32  HI for MD_MFHI, LO for MD_MFLO, otherwise 0
HI  out  32  HI register
LO  out  32  LO register

Behaviour:
- Reset: one clock edge with reset=1 gives Busy=0, HI=0, LO=0, state IDLE, counter=0. Reset also aborts any in-flight op; no result is written.
- States: IDLE and BUSY. A 4-bit down-counter runs in BUSY.
- "Start" means MDOpE is one of MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
- IDLE + Start at edge t:
  - Latch A, B and the op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; Busy=1 from cycle t+1.
- BUSY:
  - Counter decrements each edge.
  - On the edge where counter==1: write HI/LO, return to IDLE, Busy=0.
  - Busy is high for exactly N cycles. The new HI/LO is visible in the first cycle that Busy=0.
- Start while BUSY is a protocol violation (the hazard unit prevents it). It is ignored, and latched operands are not disturbed.
- MD_MTHI / MD_MTLO in IDLE: HI<=A or LO<=A at the next edge. They are ignored while BUSY.
- MD_MFHI / MD_MFLO: MDOut is combinational from the current HI/LO.
- StallMD = MDUseD & (Busy | Start). This is combinational, and covers the cycle in which the op is being issued.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero (B==0): the full DIV_CYCLES latency still elapses, but HI/LO are left unchanged.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- The result is computed from the latched operands. It may be computed combinationally and committed at the final edge.
- reset and Start at the same edge: reset wins.

Decomposition:
- Shared package (CPU parameter header):
  - MD op codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MFHI=7, MD_MFLO=8.
  - Default latency constants.
- The instruction-type to MDOp mapping lives in the existing control unit, not in this block.
- One sub-module: md_arith, purely combinational. It takes the op and latched operands and produces the 64-bit {HI,LO} result and a div-by-zero flag.
- The controller keeps the FSM, counter and HI/LO registers.

Test Plan:
1. mult A=0xFFFFFFFE (-2), B=3: Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu on the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
2. div A=-7 (0xFFFFFFF9), B=2: Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 leaves HI/LO unchanged after 10 cycles.
3. Hazard: mult issued at cycle t with MDUseD=1 (mflo) in cycles t..t+5: StallMD=1 in cycles t..t+5 (6 cycles), 0 at t+6; MDOut equals the new LO when mflo reaches E.
4. mthi A=0x12345678, then mflo-free mfhi: HI=0x12345678 after 1 edge and MDOut=0x12345678. mtlo issued while Busy: LO unchanged.
5. Reset mid-operation: assert reset at busy cycle 3 of a div: Busy=0, HI=LO=0 next cycle; no late write-back after 10 cycles.
6. div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. Back-to-back mult issued on the cycle after Busy falls is accepted with no dead cycle.
